// File: rtl/avalon_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_timer_pkg
//  Description : Shared register map, bit positions and address helpers for
//                the Avalon-MM multi-channel timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package avalon_timer_pkg;

  // Per-channel register offsets (low three address bits)
  localparam logic [2:0] c_off_status   = 3'd0;
  localparam logic [2:0] c_off_control  = 3'd1;
  localparam logic [2:0] c_off_period_l = 3'd2;
  localparam logic [2:0] c_off_period_h = 3'd3;
  localparam logic [2:0] c_off_snap_l   = 3'd4;
  localparam logic [2:0] c_off_snap_h   = 3'd5;

  // Status register bits
  localparam int c_status_to_bit  = 0;
  localparam int c_status_run_bit = 1;

  // Control register bits; START and STOP are write-only pulses
  localparam int c_ctrl_ito_bit   = 0;
  localparam int c_ctrl_cont_bit  = 1;
  localparam int c_ctrl_start_bit = 2;
  localparam int c_ctrl_stop_bit  = 3;

  // Channel field is zero-extended to this width before decode, which keeps
  // the decode uniform even when NUM_CH=1 leaves no channel bits at all.
  localparam int c_ch_field_w = 8;
  localparam int c_addr_ext_w = c_ch_field_w + 3;

  // Address width for a given channel count: {channel, 3-bit offset}
  function automatic int addr_width(input int num_ch);
    return $clog2(num_ch) + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
//  Module      : timer_channel
//  Description : One down-counting timer channel: counter, period, control,
//                status and snapshot registers, driven by decoded strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_status,
  input  logic             wr_control,
  input  logic             wr_period_l,
  input  logic             wr_period_h,
  input  logic             wr_snap,
  input  logic [15:0]      writedata,
  output logic             run,
  output logic             to,
  output logic             ito,
  output logic             cont,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic             irq
);

  localparam logic [CNT_W-1:0] c_reset_period = CNT_W'(RESET_PERIOD);
  localparam logic [CNT_W-1:0] c_low_mask     = CNT_W'(32'h0000_FFFF);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_snap;
  logic             r_run;
  logic             r_to;
  logic             r_tmo_pend;
  logic             r_ito;
  logic             r_cont;
  logic [CNT_W-1:0] w_period_next;
  logic             w_start;
  logic             w_stop;

  assign w_start = wr_control & writedata[c_ctrl_start_bit];
  assign w_stop  = wr_control & writedata[c_ctrl_stop_bit];

  // Merge a half-word write into the period; casting to CNT_W drops any
  // period_h bits that land at or above the counter width.
  always_comb begin
    w_period_next = r_period;
    if (wr_period_l) begin
      w_period_next = (w_period_next & ~c_low_mask) | CNT_W'(writedata);
    end
    if (wr_period_h) begin
      w_period_next = (w_period_next & c_low_mask) | CNT_W'({writedata, 16'h0000});
    end
  end

  // Counter, period and RUN: a period write wins, then STOP, then counting,
  // and START only matters for a stopped channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= c_reset_period;
      r_period   <= c_reset_period;
      r_run      <= 1'b0;
      r_tmo_pend <= 1'b0;
    end else begin
      r_tmo_pend <= 1'b0;
      if (wr_period_l || wr_period_h) begin
        r_period <= w_period_next;
        r_cnt    <= w_period_next;
        r_run    <= 1'b0;
      end else if (w_stop) begin
        r_run <= 1'b0;
      end else if (r_run) begin
        if (r_cnt == '0) begin
          r_cnt      <= r_period;
          r_tmo_pend <= 1'b1;
          r_run      <= r_cont;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end else if (w_start) begin
        r_run <= 1'b1;
      end
    end
  end

  // Timeout flag: set one cycle after reload, which beats a clearing write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to <= 1'b0;
    end else if (r_tmo_pend) begin
      r_to <= 1'b1;
    end else if (wr_status) begin
      r_to <= 1'b0;
    end
  end

  // Persistent control bits (interrupt enable and continuous mode).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ito  <= 1'b0;
      r_cont <= 1'b0;
    end else if (wr_control) begin
      r_ito  <= writedata[c_ctrl_ito_bit];
      r_cont <= writedata[c_ctrl_cont_bit];
    end
  end

  // Snapshot captures the live counter on any snap_l/snap_h write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap <= '0;
    end else if (wr_snap) begin
      r_snap <= r_cnt;
    end
  end

  assign run    = r_run;
  assign to     = r_to;
  assign ito    = r_ito;
  assign cont   = r_cont;
  assign period = r_period;
  assign snap   = r_snap;
  assign irq    = r_to & r_ito;

endmodule
`default_nettype wire

// File: rtl/avalon_multi_timer.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_multi_timer
//  Description : Avalon-MM slave with NUM_CH independent down-counting timers,
//                per-channel and combined interrupt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_multi_timer
  import avalon_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [addr_width(NUM_CH)-1:0] address,
  input  logic                          chipselect,
  input  logic                          write_n,
  input  logic [15:0]                   writedata,
  output logic [15:0]                   readdata,
  output logic                          irq,
  output logic [NUM_CH-1:0]             irq_vec
);

  logic [c_addr_ext_w-1:0] w_addr_ext;
  logic [c_ch_field_w-1:0] w_ch;
  logic [2:0]              w_off;
  logic                    w_wr;
  logic [15:0]             w_rdata;

  logic [NUM_CH-1:0]       w_run;
  logic [NUM_CH-1:0]       w_to;
  logic [NUM_CH-1:0]       w_ito;
  logic [NUM_CH-1:0]       w_cont;
  logic [CNT_W-1:0]        w_period [NUM_CH];
  logic [CNT_W-1:0]        w_snap   [NUM_CH];

  assign w_addr_ext = c_addr_ext_w'(address);
  assign w_ch       = w_addr_ext[c_addr_ext_w-1:3];
  assign w_off      = w_addr_ext[2:0];
  assign w_wr       = chipselect & ~write_n;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic w_hit;
      assign w_hit = w_wr & (w_ch == c_ch_field_w'(i));

      timer_channel #(
        .CNT_W        (CNT_W),
        .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_status   (w_hit & (w_off == c_off_status)),
        .wr_control  (w_hit & (w_off == c_off_control)),
        .wr_period_l (w_hit & (w_off == c_off_period_l)),
        .wr_period_h (w_hit & (w_off == c_off_period_h)),
        .wr_snap     (w_hit & ((w_off == c_off_snap_l) | (w_off == c_off_snap_h))),
        .writedata   (writedata),
        .run         (w_run[i]),
        .to          (w_to[i]),
        .ito         (w_ito[i]),
        .cont        (w_cont[i]),
        .period      (w_period[i]),
        .snap        (w_snap[i]),
        .irq         (irq_vec[i])
      );
    end
  endgenerate

  assign irq = |irq_vec;

  // Read mux; channel indices with no instance match nothing and read 0.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == c_ch_field_w'(i)) begin
        case (w_off)
          c_off_status: begin
            w_rdata[c_status_to_bit]  = w_to[i];
            w_rdata[c_status_run_bit] = w_run[i];
          end
          c_off_control: begin
            w_rdata[c_ctrl_ito_bit]  = w_ito[i];
            w_rdata[c_ctrl_cont_bit] = w_cont[i];
          end
          c_off_period_l: w_rdata = w_period[i][15:0];
          c_off_period_h: w_rdata = 16'(w_period[i] >> 16);
          c_off_snap_l:   w_rdata = w_snap[i][15:0];
          c_off_snap_h:   w_rdata = 16'(w_snap[i] >> 16);
          default:        w_rdata = '0;
        endcase
      end
    end
  end

  // Registered read data, updated every cycle independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_multi_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_multi_timer
//  Description : Directed self-checking bench for avalon_multi_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_multi_timer;

  localparam int NUM_CH = 4;
  localparam int AW     = 5;

  logic              clk;
  logic              reset_n;
  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  int n_vec;
  int n_err;

  avalon_multi_timer #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (32),
    .RESET_PERIOD (49999)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] adr(input int ch, input int off);
    return AW'(ch * 8 + off);
  endfunction

  // Write lands on the posedge following the negedge setup.
  task automatic bus_write(input int ch, input int off, input logic [15:0] d);
    @(negedge clk);
    address    = adr(ch, off);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Returns register state as it stood at the negedge the address was set.
  task automatic bus_read(input int ch, input int off, output logic [15:0] d);
    @(negedge clk);
    address = adr(ch, off);
    @(posedge clk);
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (readdata !== 16'h0 || irq !== 1'b0 || irq_vec !== 4'h0) begin
      n_err++;
      $display("FAIL reset_outputs: rd=%h irq=%b vec=%b, want 0/0/0", readdata, irq, irq_vec);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(0, 2, d);
    n_vec++;
    if (d !== 16'hC34F) begin n_err++; $display("FAIL reset_period_l: got %h want c34f", d); end
    bus_read(0, 3, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL reset_period_h: got %h want 0000", d); end
    bus_read(2, 0, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL reset_status: got %h want 0000", d); end
    bus_read(3, 4, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL reset_snap: got %h want 0000", d); end
    repeat (10) @(posedge clk);
    bus_read(1, 0, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL reset_stays_stopped: got %h want 0000", d); end
  endtask

  task automatic test_unused_offsets();
    logic [15:0] d;
    bus_write(0, 6, 16'hFFFF);
    bus_read(0, 6, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL offset6_read: got %h want 0000", d); end
    bus_read(0, 7, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL offset7_read: got %h want 0000", d); end
    bus_read(0, 2, d);
    n_vec++;
    if (d !== 16'hC34F) begin n_err++; $display("FAIL offset6_no_side_effect: got %h want c34f", d); end
  endtask

  task automatic test_one_shot();
    logic [15:0] d;
    logic        exp;
    bus_write(0, 2, 16'd5);
    bus_write(0, 3, 16'd0);
    bus_write(0, 1, 16'h0005);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      exp = (k == 7);
      n_vec++;
      if (irq_vec[0] !== exp || irq !== exp) begin
        n_err++;
        $display("FAIL one_shot_irq_cycle%0d: vec0=%b irq=%b want %b", k, irq_vec[0], irq, exp);
      end
    end
    bus_read(0, 0, d);
    n_vec++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL one_shot_status: got %h want 0001", d); end
    bus_read(0, 1, d);
    n_vec++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL one_shot_control: got %h want 0001", d); end
    bus_write(0, 0, 16'h0000);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL one_shot_clear: irq=%b want 0", irq); end
  endtask

  task automatic test_continuous();
    logic [15:0] d;
    bus_write(1, 2, 16'd3);
    bus_write(1, 1, 16'h0006);
    repeat (5) @(posedge clk);
    bus_read(1, 0, d);
    n_vec++;
    if (d !== 16'h0003) begin n_err++; $display("FAIL cont_first_to: got %h want 0003", d); end
    bus_write(1, 0, 16'h0000);
    bus_read(1, 0, d);
    n_vec++;
    if (d !== 16'h0002) begin n_err++; $display("FAIL cont_cleared: got %h want 0002", d); end
    bus_read(1, 0, d);
    n_vec++;
    if (d !== 16'h0002) begin n_err++; $display("FAIL cont_before_second: got %h want 0002", d); end
    bus_read(1, 0, d);
    n_vec++;
    if (d !== 16'h0003) begin n_err++; $display("FAIL cont_second_to: got %h want 0003", d); end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL cont_irq_masked: irq=%b want 0", irq); end
    bus_write(1, 1, 16'h000C);
    bus_read(1, 0, d);
    n_vec++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL cont_stop_priority: got %h want 0001", d); end
  endtask

  task automatic test_coincident();
    logic [15:0] d;
    bus_write(2, 2, 16'd2);
    bus_write(2, 1, 16'h0005);
    repeat (3) @(posedge clk);
    bus_write(2, 0, 16'h0000);
    n_vec++;
    if (irq_vec !== 4'b0100) begin n_err++; $display("FAIL coincident_to_kept: vec=%b want 0100", irq_vec); end
    bus_read(2, 0, d);
    n_vec++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL coincident_status: got %h want 0001", d); end
    bus_write(2, 0, 16'h0000);
    n_vec++;
    if (irq_vec !== 4'b0000) begin n_err++; $display("FAIL coincident_clear: vec=%b want 0000", irq_vec); end
  endtask

  task automatic test_snapshot();
    logic [15:0] d;
    bus_write(3, 2, 16'h0000);
    bus_write(3, 3, 16'h0001);
    bus_write(3, 1, 16'h0004);
    repeat (10) @(posedge clk);
    bus_write(3, 4, 16'h0000);
    bus_read(3, 4, d);
    n_vec++;
    if (d !== 16'hFFF6) begin n_err++; $display("FAIL snap_l: got %h want fff6", d); end
    bus_read(3, 5, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL snap_h: got %h want 0000", d); end
    bus_read(3, 3, d);
    n_vec++;
    if (d !== 16'h0001) begin n_err++; $display("FAIL snap_period_h: got %h want 0001", d); end
    bus_write(3, 1, 16'h0008);
  endtask

  task automatic test_period_write();
    logic [15:0] d;
    bus_write(0, 1, 16'h0004);
    repeat (2) @(posedge clk);
    bus_write(0, 2, 16'd100);
    bus_write(0, 4, 16'h0000);
    bus_read(0, 0, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL period_wr_run_cleared: got %h want 0000", d); end
    bus_read(0, 4, d);
    n_vec++;
    if (d !== 16'd100) begin n_err++; $display("FAIL period_wr_counter: got %0d want 100", d); end
    bus_write(0, 1, 16'h0004);
    repeat (4) @(posedge clk);
    bus_write(0, 5, 16'h0000);
    bus_read(0, 4, d);
    n_vec++;
    if (d !== 16'd96) begin n_err++; $display("FAIL period_wr_resume: got %0d want 96", d); end
    bus_read(0, 0, d);
    n_vec++;
    if (d !== 16'h0002) begin n_err++; $display("FAIL period_wr_running: got %h want 0002", d); end
  endtask

  task automatic test_reset_mid_count();
    logic [15:0] d;
    bus_write(0, 2, 16'd10);
    bus_write(0, 1, 16'h0005);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (readdata !== 16'h0 || irq !== 1'b0 || irq_vec !== 4'h0) begin
      n_err++;
      $display("FAIL midreset_async: rd=%h irq=%b vec=%b want 0/0/0", readdata, irq, irq_vec);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(0, 0, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL midreset_status: got %h want 0000", d); end
    bus_read(0, 1, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL midreset_control: got %h want 0000", d); end
    bus_write(0, 4, 16'h0000);
    bus_read(0, 4, d);
    n_vec++;
    if (d !== 16'hC34F) begin n_err++; $display("FAIL midreset_counter: got %h want c34f", d); end
    repeat (20) @(posedge clk);
    #1;
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL midreset_no_timeout: irq=%b want 0", irq); end
    bus_read(0, 0, d);
    n_vec++;
    if (d !== 16'h0000) begin n_err++; $display("FAIL midreset_no_to: got %h want 0000", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0;
    test_reset();
    test_unused_offsets();
    test_one_shot();
    test_continuous();
    test_coincident();
    test_snapshot();
    test_period_write();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
